stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 15 +
 rtl/stream_fifo_ptr.sv | 34 +++
 rtl/stream_fifo.sv | 115 +++++++++++
 tb/tb_stream_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers and limits for the single-clock stream FIFO.
package stream_fifo_pkg;

    localparam int MAX_DEPTH = 256;

    // Pointer width; never narrower than one bit so DEPTH=1 still has a legal vector.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int usage_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Pointer counter that wraps from DEPTH-1 to 0 (DEPTH need not be a power of two),
// with increment enable, synchronous clear and a configurable reset value.
module stream_fifo_ptr
    import stream_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int RESET_VAL = 0,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] RST_PTR = AW'(RESET_VAL % DEPTH);

    logic [AW-1:0] ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= RST_PTR;
        end else if (clear_i) begin
            ptr_q <= '0;
        end else if (inc_i) begin
            ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_fifo.sv
// Single-clock valid/ready stream FIFO with optional fall-through and flush.
// Define STREAM_FIFO_RESET_MSG_EN to leave RESET_MSG queued as the head entry after reset.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    DEPTH        = 8,
    parameter logic                  FALL_THROUGH = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_MSG    = '0,
    localparam int                   AW           = addr_width(DEPTH),
    localparam int                   UW           = usage_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [UW-1:0]         usage_o
);

`ifdef STREAM_FIFO_RESET_MSG_EN
    localparam logic MSG_AT_RESET = 1'b1;
`else
    localparam logic MSG_AT_RESET = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [UW-1:0]         usage_q;
    logic                  msg_q;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    assign empty = (usage_q == '0);
    assign full  = (usage_q == UW'(DEPTH));

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // ready_o never looks at ready_i (no push into a full FIFO even with a pop), and
    // flush_i masks both sides so no transfer completes in a flush cycle.
    assign ready_o = !full && !flush_i;
    assign valid_o = (FALL_THROUGH ? (!empty || valid_i) : !empty) && !flush_i;

    assign push   = valid_i && ready_o;
    assign pop    = valid_o && ready_i;
    // An empty fall-through FIFO hands the word straight to the consumer without storing it.
    assign bypass = FALL_THROUGH && empty && push && pop;
    assign wr_en  = push && !bypass;
    assign rd_en  = pop && !bypass;

    // The reset message lives in a flag rather than storage, so the array needs no reset.
    assign data_o = (FALL_THROUGH && empty) ? data_i
                  : (msg_q ? RESET_MSG : mem[rd_ptr]);
    assign usage_o = usage_q;

    stream_fifo_ptr #(
        .DEPTH     (DEPTH),
        .RESET_VAL (0)
    ) u_rd_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .inc_i   (rd_en),
        .ptr_o   (rd_ptr)
    );

    stream_fifo_ptr #(
        .DEPTH     (DEPTH),
        .RESET_VAL (int'(MSG_AT_RESET))
    ) u_wr_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .inc_i   (wr_en),
        .ptr_o   (wr_ptr)
    );

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msg_q <= MSG_AT_RESET;
        end else if (flush_i || rd_en) begin
            msg_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            usage_q <= UW'(MSG_AT_RESET);
        end else if (flush_i) begin
            usage_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   usage_q <= usage_q + UW'(1);
                2'b01:   usage_q <= usage_q - UW'(1);
                default: usage_q <= usage_q;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: three instances (DEPTH 4, DEPTH 3, DEPTH 4 fall-through)
// checked each cycle against a queue-based reference model.
module tb_stream_fifo;

    localparam int DW = 32;
    localparam logic [DW-1:0] MSG = 32'h0000_DEAD;
`ifdef STREAM_FIFO_RESET_MSG_EN
    localparam bit MSG_EN = 1'b1;
`else
    localparam bit MSG_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] din  [3];
    logic          vin  [3];
    logic          rin  [3];
    logic          fl   [3];
    logic [DW-1:0] dout [3];
    logic          vout [3];
    logic          rout [3];
    logic [2:0]    usage [3];
    logic [2:0]    use0;
    logic [1:0]    use1;
    logic [2:0]    use2;

    assign usage[0] = use0;
    assign usage[1] = {1'b0, use1};
    assign usage[2] = use2;

    stream_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1'b0), .RESET_MSG(MSG)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]), .data_i(din[0]), .valid_i(vin[0]),
        .ready_o(rout[0]), .data_o(dout[0]), .valid_o(vout[0]), .ready_i(rin[0]), .usage_o(use0)
    );

    stream_fifo #(.DATA_WIDTH(DW), .DEPTH(3), .FALL_THROUGH(1'b0), .RESET_MSG(MSG)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]), .data_i(din[1]), .valid_i(vin[1]),
        .ready_o(rout[1]), .data_o(dout[1]), .valid_o(vout[1]), .ready_i(rin[1]), .usage_o(use1)
    );

    stream_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1'b1), .RESET_MSG(MSG)) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]), .data_i(din[2]), .valid_i(vin[2]),
        .ready_o(rout[2]), .data_o(dout[2]), .valid_o(vout[2]), .ready_i(rin[2]), .usage_o(use2)
    );

    function automatic int depth_of(input int s);
        return (s == 1) ? 3 : 4;
    endfunction

    function automatic bit ft_of(input int s);
        return (s == 2);
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int s, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[%0d]: got %h expected %h", tag, s, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        if (MSG_EN) exp_q.push_back(MSG);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0; rin[i] = 1'b0; fl[i] = 1'b0; din[i] = '0;
        end
    endtask

    // Asserts reset at the current time, checks the immediate reset state, releases on a negedge.
    task automatic apply_reset();
        idle_all();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int s = 0; s < 3; s++) begin
            check("rst_usage", s, DW'(usage[s]), DW'(exp_q.size()));
            check("rst_valid", s, DW'(vout[s]), DW'(MSG_EN));
            check("rst_ready", s, DW'(rout[s]), 1);
            if (MSG_EN) check("rst_data", s, dout[s], MSG);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle on instance s: drive, check outputs against the model, advance the model.
    task automatic step(input int s, input logic v, input logic [DW-1:0] d,
                        input logic r, input logic f);
        int  cnt;
        bit  e_ready;
        bit  e_valid;
        bit  do_push;
        bit  do_pop;
        vin[s] = v; din[s] = d; rin[s] = r; fl[s] = f;
        #1;
        cnt     = exp_q.size();
        e_ready = (cnt < depth_of(s)) && !f;
        e_valid = ((cnt != 0) || (ft_of(s) && v)) && !f;
        check("usage", s, DW'(usage[s]), DW'(cnt));
        check("ready", s, DW'(rout[s]), DW'(e_ready));
        check("valid", s, DW'(vout[s]), DW'(e_valid));
        if (e_valid) check("data", s, dout[s], (cnt == 0) ? d : exp_q[0]);
        @(posedge clk);
        if (f) begin
            exp_q.delete();
        end else begin
            do_push = v && e_ready;
            do_pop  = e_valid && r;
            if (!(do_pop && cnt == 0)) begin
                if (do_pop)  void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    // Random traffic; the producer holds its word while it is not accepted.
    task automatic rand_run(input int s, input int n);
        bit            held = 1'b0;
        logic          v    = 1'b0;
        logic [DW-1:0] d    = '0;
        logic          r;
        logic          f;
        bit            acc;
        for (int i = 0; i < n; i++) begin
            if (!held) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            r   = ($urandom_range(0, 2) != 0);
            f   = ($urandom_range(0, 19) == 0);
            acc = (exp_q.size() < depth_of(s)) && !f;
            held = v && !acc;
            step(s, v, d, r, f);
        end
        idle_all();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_all();
        @(negedge clk);
        apply_reset();

        // Fill DEPTH 4 with ready_i low, try one more word, then drain in order.
        for (int k = 0; k < 4; k++) step(0, 1'b1, DW'(32'h11 * (k + 1)), 1'b0, 1'b0);
        step(0, 1'b1, 32'h55, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(0, 1'b0, '0, 1'b1, 1'b0);
        step(0, 1'b0, '0, 1'b1, 1'b0);

        // DEPTH 3: continuous push/pop of an incrementing sequence across pointer wrap.
        for (int k = 0; k < 20; k++) step(1, 1'b1, DW'(k + 1), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1, 1'b0, '0, 1'b1, 1'b0);
        rand_run(1, 300);

        // Fall-through bypass on an empty FIFO, then random traffic.
        apply_reset();
        if (MSG_EN) step(2, 1'b0, '0, 1'b1, 1'b0);
        step(2, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        step(2, 1'b0, '0, 1'b0, 1'b0);
        rand_run(2, 300);

        // Flush with a concurrent push attempt at usage 2.
        apply_reset();
        if (MSG_EN) step(0, 1'b0, '0, 1'b1, 1'b0);
        step(0, 1'b1, 32'hA1, 1'b0, 1'b0);
        step(0, 1'b1, 32'hA2, 1'b0, 1'b0);
        step(0, 1'b1, 32'hA3, 1'b0, 1'b1);
        step(0, 1'b0, '0, 1'b0, 1'b0);

        // Reset asserted mid-burst at usage 3.
        step(0, 1'b1, 32'hB1, 1'b0, 1'b0);
        step(0, 1'b1, 32'hB2, 1'b0, 1'b0);
        step(0, 1'b1, 32'hB3, 1'b0, 1'b0);
        apply_reset();
        step(0, 1'b0, '0, 1'b0, 1'b0);
        rand_run(0, 300);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
